// File: rtl/zvc_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : zvc_line_packer
// Description : Repacks variable-occupancy compressed lines (words plus their
//               metadata entries) into dense LINE_SIZE-word output lines. A
//               frame-final input line flushes the residue as a short final
//               line, which may be empty.
// Revision    : 1.0 - initial release
// ============================================================================
module zvc_line_packer #(
    parameter int WORD_WIDTH    = 8,
    parameter int LINE_SIZE     = 32,
    parameter int DIST_WIDTH    = 7,
    parameter int MAX_LIFM_RSIZ = 3,
    parameter int CNT_WIDTH     = $clog2(LINE_SIZE) + 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0]               in_lifm,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] in_mt,
    input  logic [CNT_WIDTH-1:0]                          in_cnt,
    input  logic                                          in_last,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0]               out_lifm,
    output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] out_mt,
    output logic [CNT_WIDTH-1:0]                          out_cnt,
    output logic                                          out_last
);

    localparam int MT_W     = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int ENTRIES  = 2 * LINE_SIZE;
    localparam int FILL_W   = $clog2(ENTRIES + 1);
    localparam int IDX_W    = $clog2(ENTRIES);
    localparam int IN_IDX_W = $clog2(LINE_SIZE);
    localparam int SUM_W    = $clog2(3 * LINE_SIZE) + 1;

    localparam logic [FILL_W-1:0]    LINE_F = FILL_W'(LINE_SIZE);
    localparam logic [CNT_WIDTH-1:0] LINE_C = CNT_WIDTH'(LINE_SIZE);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Buffer entries at or above r_fill are always held at zero, so the
    // output lines can be driven straight from the low half of the buffer.
    state_t              r_state;
    logic [FILL_W-1:0]   r_fill;
    logic [WORD_WIDTH-1:0] r_word [ENTRIES];
    logic [MT_W-1:0]       r_mt   [ENTRIES];

    logic [WORD_WIDTH-1:0] w_in_word [LINE_SIZE];
    logic [MT_W-1:0]       w_in_mt   [LINE_SIZE];
    logic [WORD_WIDTH-1:0] w_nword   [ENTRIES];
    logic [MT_W-1:0]       w_nmt     [ENTRIES];

    logic                w_accept;
    logic                w_emit;
    logic                w_out_last;
    logic [FILL_W-1:0]   w_out_cnt;
    logic [FILL_W-1:0]   w_cnt_clamp;
    logic [FILL_W-1:0]   w_rm;
    logic [FILL_W-1:0]   w_add;
    logic [FILL_W-1:0]   w_fill_rm;
    logic [FILL_W-1:0]   w_fill_next;

    // Unpack the flat input buses into per-word arrays.
    generate
        for (genvar g = 0; g < LINE_SIZE; g++) begin : g_unpack
            assign w_in_word[g] = in_lifm[g*WORD_WIDTH +: WORD_WIDTH];
            assign w_in_mt[g]   = in_mt[g*MT_W +: MT_W];
        end
    endgenerate

    // Output line is buffer entries 0..LINE_SIZE-1; unused entries are zero.
    generate
        for (genvar g = 0; g < LINE_SIZE; g++) begin : g_pack
            assign out_lifm[g*WORD_WIDTH +: WORD_WIDTH] = r_word[g];
            assign out_mt[g*MT_W +: MT_W]               = r_mt[g];
        end
    endgenerate

    assign w_out_cnt  = (r_fill >= LINE_F) ? LINE_F : r_fill;
    assign w_out_last = (r_state == ST_FLUSH) && (r_fill <= LINE_F);

    assign in_ready  = (r_state == ST_ACCUM) && (r_fill <= LINE_F);
    assign out_valid = (r_fill >= LINE_F) || (r_state == ST_FLUSH);
    assign out_cnt   = CNT_WIDTH'(w_out_cnt);
    assign out_last  = w_out_last;

    assign w_accept    = in_valid && in_ready;
    assign w_emit      = out_valid && out_ready;
    assign w_cnt_clamp = (in_cnt > LINE_C) ? LINE_F : FILL_W'(in_cnt);
    assign w_rm        = w_emit ? w_out_cnt : '0;
    assign w_add       = w_accept ? w_cnt_clamp : '0;
    assign w_fill_rm   = r_fill - w_rm;
    // The frame-final emit always drains the buffer completely.
    assign w_fill_next = (w_emit && w_out_last) ? '0 : (w_fill_rm + w_add);

    // Next buffer image: shift out emitted entries, then append accepted words.
    always_comb begin
        logic [SUM_W-1:0]    w_src;
        logic [IN_IDX_W-1:0] w_off;
        for (int j = 0; j < ENTRIES; j++) begin
            w_nword[j] = '0;
            w_nmt[j]   = '0;
            w_src      = SUM_W'(j) + SUM_W'(w_rm);
            w_off      = IN_IDX_W'(j - int'(w_fill_rm));
            if (w_src < SUM_W'(ENTRIES)) begin
                w_nword[j] = r_word[w_src[IDX_W-1:0]];
                w_nmt[j]   = r_mt[w_src[IDX_W-1:0]];
            end
            if (w_accept && (FILL_W'(j) >= w_fill_rm) &&
                (SUM_W'(j) < (SUM_W'(w_fill_rm) + SUM_W'(w_add)))) begin
                w_nword[j] = w_in_word[w_off];
                w_nmt[j]   = w_in_mt[w_off];
            end
        end
    end

    // Control FSM, fill counter and buffer storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACCUM;
            r_fill  <= '0;
            for (int j = 0; j < ENTRIES; j++) begin
                r_word[j] <= '0;
                r_mt[j]   <= '0;
            end
        end else begin
            r_fill <= w_fill_next;
            for (int j = 0; j < ENTRIES; j++) begin
                r_word[j] <= w_nword[j];
                r_mt[j]   <= w_nmt[j];
            end
            case (r_state)
                ST_ACCUM: if (w_accept && in_last)   r_state <= ST_FLUSH;
                ST_FLUSH: if (w_emit && w_out_last)  r_state <= ST_ACCUM;
                default:                             r_state <= ST_ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zvc_line_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_zvc_line_packer
// Description : Randomized and directed bench for zvc_line_packer. A monitor
//               keeps a word-stream reference (queue of pending words plus a
//               frame-ending flag) and checks every emitted line against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zvc_line_packer;

    localparam int WW  = 8;
    localparam int L   = 32;
    localparam int DW  = 7;
    localparam int RS  = 3;
    localparam int CW  = $clog2(L) + 1;
    localparam int MTW = DW * RS;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [L*WW-1:0]      in_lifm = '0;
    logic [L*MTW-1:0]     in_mt = '0;
    logic [CW-1:0]        in_cnt = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [L*WW-1:0]      out_lifm;
    logic [L*MTW-1:0]     out_mt;
    logic [CW-1:0]        out_cnt;
    logic                 out_last;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: random

    // Reference model: words accepted but not yet emitted, in stream order.
    logic [WW-1:0]  q_word[$];
    logic [MTW-1:0] q_mt[$];
    bit             flushing = 1'b0;

    logic             hold_vld = 1'b0;
    logic [L*WW-1:0]  hold_lifm;
    logic [L*MTW-1:0] hold_mt;
    logic [CW-1:0]    hold_cnt;
    logic             hold_last;

    zvc_line_packer #(
        .WORD_WIDTH   (WW),
        .LINE_SIZE    (L),
        .DIST_WIDTH   (DW),
        .MAX_LIFM_RSIZ(RS),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_lifm  (in_lifm),
        .in_mt    (in_mt),
        .in_cnt   (in_cnt),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_lifm (out_lifm),
        .out_mt   (out_mt),
        .out_cnt  (out_cnt),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: sampled on the falling edge, i.e. the handshake
    // values that the next rising edge will act on.
    always @(negedge clk) begin : mon
        int n;
        int c;
        logic e_rdy;
        logic e_vld;
        logic e_last;
        logic [L*WW-1:0]  e_lifm;
        logic [L*MTW-1:0] e_mt;
        if (reset) begin
            q_word.delete();
            q_mt.delete();
            flushing = 1'b0;
            hold_vld = 1'b0;
        end else begin
            n     = q_word.size();
            e_rdy = !flushing && (n <= L);
            e_vld = flushing || (n >= L);
            checks++;
            if (in_ready !== e_rdy) begin
                errors++;
                $display("FAIL in_ready actual=%0b required=%0b pending=%0d at %0t", in_ready, e_rdy, n, $time);
            end
            checks++;
            if (out_valid !== e_vld) begin
                errors++;
                $display("FAIL out_valid actual=%0b required=%0b pending=%0d at %0t", out_valid, e_vld, n, $time);
            end
            if (hold_vld) begin
                checks++;
                if ({out_lifm, out_mt, out_cnt, out_last} !== {hold_lifm, hold_mt, hold_cnt, hold_last}) begin
                    errors++;
                    $display("FAIL stall_hold actual_cnt=%0d required_cnt=%0d actual_last=%0b required_last=%0b at %0t",
                             out_cnt, hold_cnt, out_last, hold_last, $time);
                end
            end
            hold_vld  = out_valid && !out_ready;
            hold_lifm = out_lifm;
            hold_mt   = out_mt;
            hold_cnt  = out_cnt;
            hold_last = out_last;

            if (out_valid && out_ready) begin
                c      = (n < L) ? n : L;
                e_last = flushing && (n <= L);
                e_lifm = '0;
                e_mt   = '0;
                for (int i = 0; i < c; i++) begin
                    e_lifm[i*WW +: WW]   = q_word[i];
                    e_mt[i*MTW +: MTW]   = q_mt[i];
                end
                checks++;
                if (out_cnt !== CW'(c) || out_last !== e_last) begin
                    errors++;
                    $display("FAIL line_hdr actual cnt=%0d last=%0b required cnt=%0d last=%0b at %0t",
                             out_cnt, out_last, c, e_last, $time);
                end
                checks++;
                if (out_lifm !== e_lifm) begin
                    errors++;
                    $display("FAIL line_lifm actual=%h required=%h", out_lifm, e_lifm);
                end
                checks++;
                if (out_mt !== e_mt) begin
                    errors++;
                    $display("FAIL line_mt actual=%h required=%h", out_mt, e_mt);
                end
                for (int i = 0; i < c; i++) begin
                    void'(q_word.pop_front());
                    void'(q_mt.pop_front());
                end
                if (e_last) flushing = 1'b0;
            end

            if (in_valid && in_ready) begin
                c = (int'(in_cnt) > L) ? L : int'(in_cnt);
                for (int i = 0; i < c; i++) begin
                    q_word.push_back(in_lifm[i*WW +: WW]);
                    q_mt.push_back(in_mt[i*MTW +: MTW]);
                end
                if (in_last) flushing = 1'b1;
            end
        end
    end

    // Downstream ready generator.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = (rdy_mode == 1);
        end
    end

    task automatic send_line(input int cnt, input bit last);
        bit acc;
        for (int i = 0; i < L; i++) begin
            in_lifm[i*WW +: WW]  = WW'($urandom);
            in_mt[i*MTW +: MTW]  = MTW'($urandom);
        end
        in_cnt   = CW'(cnt);
        in_last  = last;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted cnt=%0d at %0t", cnt, $time);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(posedge clk);
            done = (q_word.size() == 0) && !flushing;
        end
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout actual=pending%0d required=pending0", q_word.size());
        end
    endtask

    initial begin
        // Reset held for two cycles.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cnt",   64'(out_cnt),   64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_lifm_zero", 64'(out_lifm == '0), 64'd1);
        @(posedge clk); #1;

        // Two partial lines combine into one full line.
        rdy_mode = 1;
        send_line(20, 0);
        send_line(12, 0);
        drain();

        // Short final line.
        send_line(20, 0);
        send_line(20, 0);
        send_line(5, 1);
        drain();

        // Backpressure: buffer fills to two lines and stalls the input.
        rdy_mode = 0;
        @(posedge clk); #1;
        send_line(32, 0);
        send_line(32, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_cnt",  64'(out_cnt),  64'd32);
        chk("full_out_last", 64'(out_last), 64'd0);
        rdy_mode = 1;
        drain();
        @(negedge clk);
        chk("drained_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Empty frame.
        send_line(0, 1);
        drain();

        // Over-range counts clamp to a full line.
        send_line(45, 0);
        send_line(63, 1);
        drain();

        // Reset during flush discards buffered words.
        rdy_mode = 0;
        @(posedge clk); #1;
        send_line(20, 0);
        send_line(20, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("flush_rst_out_valid", 64'(out_valid), 64'd0);
        chk("flush_rst_in_ready",  64'(in_ready),  64'd1);
        rdy_mode = 1;
        send_line(32, 0);
        drain();

        // Randomized traffic with random backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 150; k++) begin
            send_line(($urandom_range(0, 7) == 0) ? int'($urandom_range(33, 63)) : int'($urandom_range(0, 32)),
                      ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        send_line(int'($urandom_range(0, 32)), 1);
        drain();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/zvc_line_packer.md
ZVC_LINE_PACKER -- requirements
Module: zvc_line_packer

Interface
REQ-001 Parameter WORD_WIDTH, default 8: bits per LIFM word.
REQ-002 Parameter LINE_SIZE, default 32: words per line, in and out.
REQ-003 Parameter DIST_WIDTH, default 7: bits per metadata distance field.
REQ-004 Parameter MAX_LIFM_RSIZ, default 3: distance fields per word; MT entry width = DIST_WIDTH*MAX_LIFM_RSIZ.
REQ-005 Parameter CNT_WIDTH, default $clog2(LINE_SIZE)+1: width of word-count ports.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  compressed line present.
REQ-009 in_ready  output  1  packer accepts the line this cycle.
REQ-010 in_lifm  input  LINE_SIZE*WORD_WIDTH  compressed words; word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-011 in_mt  input  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  metadata entry per word, same indexing.
REQ-012 in_cnt  input  CNT_WIDTH  number of valid words, packed at indices 0..in_cnt-1.
REQ-013 in_last  input  1  final line of frame.
REQ-014 out_valid  output  1  packed line available.
REQ-015 out_ready  input  1  downstream accepts the line.
REQ-016 out_lifm  output  LINE_SIZE*WORD_WIDTH  packed words.
REQ-017 out_mt  output  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  packed metadata.
REQ-018 out_cnt  output  CNT_WIDTH  valid words in out line; LINE_SIZE except the frame's final line.
REQ-019 out_last  output  1  final packed line of frame.

Function
REQ-020 Storage: 2*LINE_SIZE word+MT entries plus fill counter (0..2*LINE_SIZE); all outputs driven from registered state only.
REQ-021 States: ACCUM and FLUSH; reset enters ACCUM.
REQ-022 in_ready = 1 in ACCUM when fill <= LINE_SIZE; 0 in FLUSH.
REQ-023 Accept = in_valid & in_ready; emit = out_valid & out_ready.
REQ-024 On accept, in words 0..min(in_cnt,LINE_SIZE)-1 append at entries fill.. in order; words at index >= in_cnt ignored; in_cnt > LINE_SIZE clamps to LINE_SIZE.
REQ-025 out_valid = 1 when fill >= LINE_SIZE (ACCUM or FLUSH), or in FLUSH with any fill including 0.
REQ-026 out_lifm/out_mt present entries 0..LINE_SIZE-1; entries at index >= out_cnt drive zero.
REQ-027 out_cnt = min(fill, LINE_SIZE); out_last = 1 iff state is FLUSH and fill <= LINE_SIZE.
REQ-028 On emit, remove out_cnt entries; remaining shift down to entry 0, order preserved.
REQ-029 Simultaneous accept and emit in one cycle: remove first, then append; next fill = fill - out_cnt + clamped in_cnt.
REQ-030 Accepting a line with in_last = 1 moves ACCUM -> FLUSH after the append.
REQ-031 Emitting a line with out_last = 1 moves FLUSH -> ACCUM, fill = 0.
REQ-032 Empty frame (fill 0 after accepting in_last): exactly one line emitted with out_cnt = 0, out_last = 1, data zero.
REQ-033 Latency: accepted line completing fill >= LINE_SIZE raises out_valid on the next cycle.
REQ-034 While out_valid = 1 and out_ready = 0, out_lifm, out_mt, out_cnt, out_last hold stable.
REQ-035 Input not accepted when in_ready = 0 regardless of in_valid; no data loss or duplication.

Reset
REQ-036 While reset = 1 at a clock edge: fill = 0, state = ACCUM, out_valid = 0, out_cnt = 0, out_last = 0, out_lifm = 0, out_mt = 0, in_ready = 1 on the following cycle.
REQ-037 Reset asserted mid-frame or mid-FLUSH discards all buffered words; no partial line emitted afterwards.

Verification
REQ-038 Reset held 2 cycles -> out_valid=0, out_cnt=0, out_last=0, in_ready=1.
REQ-039 in_cnt=20 then 12, out_ready=1 -> one line, out_cnt=32, words 0..19 from line A, 20..31 from line B, out_last=0.
REQ-040 in_cnt=20, 20, then 5 with in_last -> line 1 out_cnt=32; line 2 out_cnt=13, out_last=1, words 13..31 zero; state back to ACCUM.
REQ-041 out_ready=0, in_cnt=32 twice -> both accepted, fill=64, in_ready=0, outputs stable; out_ready=1 -> two full lines, then in_ready=1.
REQ-042 in_cnt=0 with in_last on empty buffer -> single line out_cnt=0, out_last=1.
REQ-043 Reset pulsed during FLUSH with fill=40 -> out_valid=0 next cycle; subsequent in_cnt=32 line emerges intact, out_cnt=32.
